// File: rtl/pbvi_pkg.sv
// Shared types and helpers for the PBVI value-iteration controller and backup chain.
package pbvi_pkg;

    localparam int DW_DEFAULT = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_CMP,
        S_COMMIT,
        S_DONE
    } pbvi_state_e;

    // Operands are zero-extended to 32 bits so any DW up to 32 can share this helper.
    function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Belief b(s0) of grid point idx, evenly spaced over [0, 2^dw-1].
    function automatic logic [31:0] belief_grid(input int idx, input int n_points, input int dw);
        longint full;
        full = (longint'(1) << dw) - 1;
        if (n_points <= 1) return 32'd0;
        return 32'(full * longint'(idx) / longint'(n_points - 1));
    endfunction

endpackage

// File: rtl/pbvi_iter_ctrl_if.sv
// Launch/result bundle between the iteration controller and the step1..step3 backup chain.
interface pbvi_iter_ctrl_if #(
    parameter int N_POINTS  = 16,
    parameter int N_STATES  = 2,
    parameter int N_ACTIONS = 3,
    parameter int DW        = 16
);
    localparam int AW = $clog2(N_ACTIONS);

    logic                                        bkp_en;
    logic [N_POINTS-1:0][N_STATES-1:0][DW-1:0]   alpha_cur;
    logic                                        bkp_done;
    logic [N_POINTS-1:0][N_STATES-1:0][DW-1:0]   bkp_alpha;
    logic [N_POINTS-1:0][AW-1:0]                 bkp_action;

    modport ctrl  (output bkp_en, output alpha_cur, input  bkp_done, input  bkp_alpha, input  bkp_action);
    modport chain (input  bkp_en, input  alpha_cur, output bkp_done, output bkp_alpha, output bkp_action);

endinterface

// File: rtl/pbvi_iter_ctrl_cmp.sv
// Sequential max-abs-difference scan: one element per cycle from start until last.
module pbvi_alpha_cmp
    import pbvi_pkg::*;
#(
    parameter int N_ELEM = 32,
    parameter int DW     = 16,
    localparam int IW    = $clog2(N_ELEM)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] new_val,
    input  logic [DW-1:0] old_val,
    output logic [IW-1:0] idx,
    output logic          last,
    output logic [DW-1:0] max_diff
);

    logic          active;
    logic [DW-1:0] acc;
    logic [DW-1:0] d;

    assign d        = DW'(abs_diff(32'(new_val), 32'(old_val)));
    // Running max including the element currently presented, so it is final on the last cycle.
    assign max_diff = (d > acc) ? d : acc;
    assign last     = active && (idx == IW'(N_ELEM - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            idx    <= '0;
            acc    <= '0;
        end else if (start) begin
            active <= 1'b1;
            idx    <= '0;
            acc    <= '0;
        end else if (active) begin
            acc <= max_diff;
            idx <= idx + IW'(1);
            if (last) active <= 1'b0;
        end
    end

endmodule

// File: rtl/pbvi_iter_ctrl.sv
// Bounded value-iteration loop: launches backups, scans for convergence, commits alpha/actions.
//
// state  | meaning
// IDLE   | waiting for start; committed bank and status held
// LAUNCH | bkp_en high, wait counter loaded
// WAIT   | waiting for bkp_done, bounded by TIMEOUT cycles
// CMP    | scanning new vs committed alpha, one element per cycle
// COMMIT | bank/actions committed, stop or relaunch decided
// DONE   | done pulse, then back to IDLE
module pbvi_iter_ctrl
    import pbvi_pkg::*;
#(
    parameter int N_POINTS  = 16,
    parameter int N_STATES  = 2,
    parameter int N_ACTIONS = 3,
    parameter int DW        = DW_DEFAULT,
    parameter int TIMEOUT   = 1024,
    localparam int AW       = $clog2(N_ACTIONS)
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      start,
    input  logic                                      abort,
    input  logic [15:0]                               max_iter,
    input  logic [DW-1:0]                             epsilon,
    input  logic [N_POINTS-1:0][N_STATES-1:0][DW-1:0] alpha_init,
    pbvi_iter_ctrl_if.ctrl                            bkp,
    output logic [N_POINTS-1:0][AW-1:0]               point_action,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      converged,
    output logic                                      timeout_err,
    output logic [15:0]                               iter_cnt,
    output logic [DW-1:0]                             max_diff
);

    localparam int NE = N_POINTS * N_STATES;
    localparam int IW = $clog2(NE);
    localparam int TW = $clog2(TIMEOUT + 1);

    pbvi_state_e                               state;
    logic [TW-1:0]                             wait_cnt;
    logic [15:0]                               max_iter_q;
    logic [DW-1:0]                             eps_q;
    logic [N_POINTS-1:0][N_STATES-1:0][DW-1:0] alpha_new;
    logic [N_POINTS-1:0][AW-1:0]               act_new;

    // Flat views: element p*N_STATES+s is point p, state s.
    logic [NE-1:0][DW-1:0] cur_flat;
    logic [NE-1:0][DW-1:0] new_flat;
    assign cur_flat = bkp.alpha_cur;
    assign new_flat = alpha_new;

    logic          cmp_start;
    logic          cmp_last;
    logic [IW-1:0] cmp_idx;
    logic [DW-1:0] cmp_max;

    assign cmp_start = (state == S_WAIT) && bkp.bkp_done && !abort;

    pbvi_alpha_cmp #(.N_ELEM(NE), .DW(DW)) u_cmp (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (cmp_start),
        .new_val  (new_flat[cmp_idx]),
        .old_val  (cur_flat[cmp_idx]),
        .idx      (cmp_idx),
        .last     (cmp_last),
        .max_diff (cmp_max)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            bkp.bkp_en    <= 1'b0;
            bkp.alpha_cur <= '0;
            point_action  <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            converged     <= 1'b0;
            timeout_err   <= 1'b0;
            iter_cnt      <= '0;
            max_diff      <= '0;
            wait_cnt      <= '0;
            max_iter_q    <= 16'd1;
            eps_q         <= '0;
            alpha_new     <= '0;
            act_new       <= '0;
        end else begin
            bkp.bkp_en <= 1'b0;
            done       <= 1'b0;
            if (abort && state != S_IDLE) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            bkp.alpha_cur <= alpha_init;
                            max_iter_q    <= (max_iter == 16'd0) ? 16'd1 : max_iter;
                            eps_q         <= epsilon;
                            iter_cnt      <= '0;
                            converged     <= 1'b0;
                            timeout_err   <= 1'b0;
                            point_action  <= '0;
                            bkp.bkp_en    <= 1'b1;
                            busy          <= 1'b1;
                            state         <= S_LAUNCH;
                        end
                    end
                    S_LAUNCH: begin
                        wait_cnt <= TW'(TIMEOUT - 1);
                        state    <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (bkp.bkp_done) begin
                            alpha_new <= bkp.bkp_alpha;
                            act_new   <= bkp.bkp_action;
                            state     <= S_CMP;
                        end else if (wait_cnt == '0) begin
                            timeout_err <= 1'b1;
                            done        <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            wait_cnt <= wait_cnt - TW'(1);
                        end
                    end
                    S_CMP: begin
                        if (cmp_last) begin
                            max_diff <= cmp_max;
                            state    <= S_COMMIT;
                        end
                    end
                    S_COMMIT: begin
                        bkp.alpha_cur <= alpha_new;
                        point_action  <= act_new;
                        iter_cnt      <= iter_cnt + 16'd1;
                        if (max_diff <= eps_q) begin
                            converged <= 1'b1;
                            done      <= 1'b1;
                            state     <= S_DONE;
                        end else if ((17'(iter_cnt) + 17'd1) >= 17'(max_iter_q)) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            bkp.bkp_en <= 1'b1;
                            state      <= S_LAUNCH;
                        end
                    end
                    S_DONE: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pbvi_iter_ctrl.sv
// Self-checking bench for pbvi_iter_ctrl with a behavioural backup-chain model.
module tb_pbvi_iter_ctrl;

    localparam int NP = 16;
    localparam int NS = 2;
    localparam int NA = 3;
    localparam int TO = 8;

    logic                              clk;
    logic                              rst_n;
    logic                              start;
    logic                              abort;
    logic [15:0]                       max_iter;
    logic [15:0]                       epsilon;
    logic [NP-1:0][NS-1:0][15:0]       alpha_init;
    logic [NP-1:0][1:0]                point_action;
    logic                              busy;
    logic                              done;
    logic                              converged;
    logic                              timeout_err;
    logic [15:0]                       iter_cnt;
    logic [15:0]                       max_diff;

    pbvi_iter_ctrl_if #(.N_POINTS(NP), .N_STATES(NS), .N_ACTIONS(NA), .DW(16)) bkp ();

    pbvi_iter_ctrl #(.N_POINTS(NP), .N_STATES(NS), .N_ACTIONS(NA), .DW(16), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .max_iter     (max_iter),
        .epsilon      (epsilon),
        .alpha_init   (alpha_init),
        .bkp          (bkp.ctrl),
        .point_action (point_action),
        .busy         (busy),
        .done         (done),
        .converged    (converged),
        .timeout_err  (timeout_err),
        .iter_cnt     (iter_cnt),
        .max_diff     (max_diff)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mode: 0 = alpha_cur + val, 1 = constant val, 2 = never respond
    typedef struct {
        int          k;
        int          mode;
        logic [15:0] val;
        logic [1:0]  act;
        logic [15:0] mi;
        logic [15:0] eps;
        logic [15:0] init;
        int          e_en;
        logic [15:0] e_iter;
        logic        e_conv;
        logic        e_to;
        logic [15:0] e_md;
        logic [15:0] e_alpha;
        logic [1:0]  e_pa;
        int          e_done;
    } vec_t;

    vec_t vecs[9];
    vec_t exp_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    int          m_k;
    int          m_mode = 2;
    logic [15:0] m_val;
    logic [1:0]  m_act;
    int          m_abort_at = 0;
    int          m_resp_n = 0;

    // Backup chain model: answers bkp_en after m_k cycles with one-cycle bkp_done.
    initial begin
        bkp.bkp_done   = 1'b0;
        bkp.bkp_alpha  = '0;
        bkp.bkp_action = '0;
        abort          = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bkp.bkp_en && m_mode != 2) begin
                m_resp_n++;
                repeat (m_k) @(posedge clk);
                #1;
                for (int p = 0; p < NP; p++) begin
                    for (int s = 0; s < NS; s++)
                        bkp.bkp_alpha[p][s] = (m_mode == 0) ? bkp.alpha_cur[p][s] + m_val : m_val;
                    bkp.bkp_action[p] = m_act;
                end
                bkp.bkp_done = 1'b1;
                if (m_abort_at != 0 && m_resp_n == m_abort_at) abort = 1'b1;
                @(posedge clk);
                #1;
                bkp.bkp_done  = 1'b0;
                abort         = 1'b0;
                bkp.bkp_alpha = {NP*NS{16'hDEAD}};
            end
        end
    end

    task automatic chk(input string tag, input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h expected %0h", tag, name, got, exp);
        end
    endtask

    task automatic chk_alpha(input string tag, input logic [15:0] exp);
        logic [15:0] bad;
        bad = exp;
        for (int p = 0; p < NP; p++)
            for (int s = 0; s < NS; s++)
                if (bkp.alpha_cur[p][s] !== exp) bad = bkp.alpha_cur[p][s];
        chk(tag, "alpha_cur", 32'(bad), 32'(exp));
    endtask

    task automatic chk_pa(input string tag, input logic [1:0] exp);
        logic [1:0] bad;
        bad = exp;
        for (int p = 0; p < NP; p++)
            if (point_action[p] !== exp) bad = point_action[p];
        chk(tag, "point_action", 32'(bad), 32'(exp));
    endtask

    task automatic drive_start(input logic [15:0] mi, input logic [15:0] eps, input logic [15:0] init);
        @(negedge clk);
        max_iter = mi;
        epsilon  = eps;
        for (int p = 0; p < NP; p++)
            for (int s = 0; s < NS; s++)
                alpha_init[p][s] = init;
        start = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int   cyc;
        int   en_cnt;
        bit   got;
        vec_t e;
        m_k = v.k; m_mode = v.mode; m_val = v.val; m_act = v.act;
        m_abort_at = 0; m_resp_n = 0;
        drive_start(v.mi, v.eps, v.init);
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        start  = 1'b0;
        cyc    = 1;
        en_cnt = 0;
        got    = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (bkp.bkp_en) en_cnt++;
            if (done) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        e = exp_q.pop_front();
        chk(tag, "done_seen", 32'(got), 32'd1);
        chk(tag, "done_cycle", 32'(cyc), 32'(e.e_done));
        chk(tag, "bkp_en_count", 32'(en_cnt), 32'(e.e_en));
        chk(tag, "busy_in_done", 32'(busy), 32'd1);
        chk(tag, "iter_cnt", 32'(iter_cnt), 32'(e.e_iter));
        chk(tag, "converged", 32'(converged), 32'(e.e_conv));
        chk(tag, "timeout_err", 32'(timeout_err), 32'(e.e_to));
        chk(tag, "max_diff", 32'(max_diff), 32'(e.e_md));
        chk_alpha(tag, e.e_alpha);
        chk_pa(tag, e.e_pa);
        @(posedge clk);
        #1;
        chk(tag, "done_one_cycle", 32'(done), 32'd0);
        chk(tag, "busy_after", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int cyc;
        int en_cnt;
        int done_cnt;
        int idle_cyc;

        //           k  md val       act  mi     eps      init      en iter   conv  to    md        alpha     pa    done
        vecs[0] = '{3, 1, 16'h1008, 2'd1, 16'd5, 16'h0010, 16'h1000, 1, 16'd1, 1'b1, 1'b0, 16'h0008, 16'h1008, 2'd1, 38};
        vecs[1] = '{2, 0, 16'h0100, 2'd2, 16'd3, 16'h0010, 16'h1000, 3, 16'd3, 1'b0, 1'b0, 16'h0100, 16'h1300, 2'd2, 109};
        vecs[2] = '{0, 2, 16'h0000, 2'd0, 16'd4, 16'h0010, 16'h2222, 1, 16'd0, 1'b0, 1'b1, 16'h0100, 16'h2222, 2'd0, 10};
        vecs[3] = '{1, 1, 16'h0000, 2'd3, 16'd1, 16'h0010, 16'hFFF0, 1, 16'd1, 1'b0, 1'b0, 16'hFFF0, 16'h0000, 2'd3, 36};
        vecs[4] = '{4, 0, 16'h0800, 2'd1, 16'd0, 16'h0000, 16'h0500, 1, 16'd1, 1'b0, 1'b0, 16'h0800, 16'h0D00, 2'd1, 39};
        vecs[5] = '{1, 0, 16'h0020, 2'd2, 16'd10, 16'h0020, 16'h0100, 1, 16'd1, 1'b1, 1'b0, 16'h0020, 16'h0120, 2'd2, 36};
        vecs[6] = '{1, 0, 16'h0020, 2'd2, 16'd2, 16'h001F, 16'h0100, 2, 16'd2, 1'b0, 1'b0, 16'h0020, 16'h0140, 2'd2, 71};
        vecs[7] = '{8, 0, 16'h0004, 2'd1, 16'd3, 16'h0010, 16'h0300, 1, 16'd1, 1'b1, 1'b0, 16'h0004, 16'h0304, 2'd1, 43};
        vecs[8] = '{9, 0, 16'h0004, 2'd3, 16'd3, 16'h0010, 16'h0300, 1, 16'd0, 1'b0, 1'b1, 16'h0004, 16'h0300, 2'd0, 10};

        rst_n      = 1'b0;
        start      = 1'b0;
        max_iter   = '0;
        epsilon    = '0;
        alpha_init = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        chk("reset", "busy", 32'(busy), 32'd0);
        chk("reset", "done", 32'(done), 32'd0);
        chk("reset", "bkp_en", 32'(bkp.bkp_en), 32'd0);
        chk("reset", "converged", 32'(converged), 32'd0);
        chk("reset", "timeout_err", 32'(timeout_err), 32'd0);
        chk("reset", "iter_cnt", 32'(iter_cnt), 32'd0);
        chk("reset", "max_diff", 32'(max_diff), 32'd0);
        chk_alpha("reset", 16'h0000);
        chk_pa("reset", 2'd0);

        for (int i = 0; i < 9; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // Abort coinciding with the second bkp_done; a start pulse mid-run must be ignored.
        m_k = 3; m_mode = 0; m_val = 16'h0100; m_act = 2'd2;
        m_abort_at = 2; m_resp_n = 0;
        drive_start(16'd3, 16'h0010, 16'h0400);
        @(posedge clk);
        #1;
        start    = 1'b0;
        cyc      = 1;
        en_cnt   = 0;
        done_cnt = 0;
        idle_cyc = -1;
        for (int i = 0; i < 200; i++) begin
            if (bkp.bkp_en) en_cnt++;
            if (done) done_cnt++;
            if (!busy) begin
                idle_cyc = cyc;
                break;
            end
            if (cyc == 2) begin
                start = 1'b1;
                for (int p = 0; p < NP; p++)
                    for (int s = 0; s < NS; s++)
                        alpha_init[p][s] = 16'h7777;
            end else if (cyc == 3) begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        for (int i = 0; i < 5; i++) begin
            if (done) done_cnt++;
            @(posedge clk);
            #1;
        end
        chk("abort", "idle_cycle", 32'(idle_cyc), 32'd42);
        chk("abort", "bkp_en_count", 32'(en_cnt), 32'd2);
        chk("abort", "done_pulses", 32'(done_cnt), 32'd0);
        chk("abort", "iter_cnt", 32'(iter_cnt), 32'd1);
        chk("abort", "max_diff", 32'(max_diff), 32'h0100);
        chk("abort", "converged", 32'(converged), 32'd0);
        chk_alpha("abort", 16'h0500);
        chk_pa("abort", 2'd2);
        m_abort_at = 0;

        // Asynchronous reset while the compare scan is running.
        m_k = 2; m_mode = 0; m_val = 16'h0010; m_act = 2'd1; m_resp_n = 0;
        drive_start(16'd4, 16'h0000, 16'h0600);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("rst_cmp", "busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_cmp", "busy", 32'(busy), 32'd0);
        chk("rst_cmp", "done", 32'(done), 32'd0);
        chk("rst_cmp", "bkp_en", 32'(bkp.bkp_en), 32'd0);
        chk("rst_cmp", "iter_cnt", 32'(iter_cnt), 32'd0);
        chk("rst_cmp", "max_diff", 32'(max_diff), 32'd0);
        chk("rst_cmp", "converged", 32'(converged), 32'd0);
        chk("rst_cmp", "timeout_err", 32'(timeout_err), 32'd0);
        chk_alpha("rst_cmp", 16'h0000);
        chk_pa("rst_cmp", 2'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        run_vec(vecs[0], "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no end of test, expected completion");
        $fatal(1);
    end

endmodule
